// File: rtl/multi_ramp_pwm_pkg.sv
// Shared definitions for the multi-channel ramp-modulated PWM generator:
// channel mode encodings and the ramp step divider calculation.
package multi_ramp_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_TRI  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  // Clocks per ramp step so that a full 2^bits-step ramp repeats at ramp_freq.
  function automatic int unsigned calc_step_div(input int unsigned clk_hz,
                                                input int unsigned ramp_freq,
                                                input int unsigned bits);
    longint unsigned den;
    den = longint'(ramp_freq) * (64'd1 << bits);
    if (den == 0) return 0;
    return int'(longint'(clk_hz) / den);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shapes the phase-shifted shared ramp into a duty value,
// latches it at the carrier boundary and compares it against the carrier.
module pwm_channel
  import multi_ramp_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] phase,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [PWM_BITS-1:0] ramp,
  input  logic                load,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] v;
  logic [PWM_BITS-1:0] shaped;
  logic [PWM_BITS-1:0] duty_d, duty_q;
  logic                pwm_d, pwm_q;

  always_comb begin
    v      = ramp + phase;
    shaped = duty_q;
    case (mode_e'(mode))
      MODE_UP:   shaped = v;
      MODE_DOWN: shaped = ~v;
      // Triangle folds the upper half back down, always even-valued.
      MODE_TRI:  shaped = v[PWM_BITS-1] ? {~v[PWM_BITS-2:0], 1'b0}
                                        : { v[PWM_BITS-2:0], 1'b0};
      MODE_HOLD: shaped = duty_q;
    endcase
    duty_d = load ? shaped : duty_q;
    pwm_d  = en & (cnt < duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/multi_ramp_pwm.sv
// Multi-channel PWM generator: shared carrier counter and slow shared ramp
// feeding N_CH independently shaped, phase-offset PWM channels.
module multi_ramp_pwm
  import multi_ramp_pwm_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned RAMP_FREQ = 1_000,
  parameter int unsigned PWM_BITS  = 10,
  parameter int unsigned N_CH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH-1:0]              en,
  input  logic [2*N_CH-1:0]            mode,
  input  logic [PWM_BITS*N_CH-1:0]     phase,
  output logic [N_CH-1:0]              pwm_out,
  output logic                         ramp_wrap
);

  localparam int unsigned STEP_DIV = calc_step_div(CLK_HZ, RAMP_FREQ, PWM_BITS);
  localparam int unsigned DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;

  if (STEP_DIV < 1) begin : g_bad_step_div
    $error("multi_ramp_pwm: STEP_DIV < 1, clock too slow for RAMP_FREQ and PWM_BITS");
  end
  if (PWM_BITS < 3 || PWM_BITS > 16) begin : g_bad_bits
    $error("multi_ramp_pwm: PWM_BITS must be in 3..16");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("multi_ramp_pwm: N_CH must be in 1..16");
  end

  logic [PWM_BITS-1:0] cnt_d, cnt_q;
  logic [DIV_W-1:0]    div_d, div_q;
  logic [PWM_BITS-1:0] r_d, r_q;
  logic                ramp_wrap_d, ramp_wrap_q;
  logic                step_tick;
  logic                load;

  always_comb begin
    step_tick   = (div_q == DIV_LAST);
    div_d       = step_tick ? '0 : div_q + 1'b1;
    cnt_d       = cnt_q + 1'b1;
    r_d         = step_tick ? r_q + 1'b1 : r_q;
    ramp_wrap_d = step_tick && (r_q == CNT_MAX);
    load        = (cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      div_q       <= '0;
      r_q         <= '0;
      ramp_wrap_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      r_q         <= r_d;
      ramp_wrap_q <= ramp_wrap_d;
    end
  end

  assign ramp_wrap = ramp_wrap_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .mode    (mode[2*i +: 2]),
      .phase   (phase[PWM_BITS*i +: PWM_BITS]),
      .cnt     (cnt_q),
      .ramp    (r_q),
      .load    (load),
      .pwm_out (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_multi_ramp_pwm.sv
// Self-checking bench for multi_ramp_pwm with B=4, STEP_DIV=16, N_CH=4.
module tb_multi_ramp_pwm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  en = 4'hF;
  logic [7:0]  mode = 8'h00;
  logic [15:0] phase = 16'h0000;
  logic [3:0]  pwm_out;
  logic        ramp_wrap;

  always #5 clk = ~clk;

  multi_ramp_pwm #(
    .CLK_HZ(2560),
    .RAMP_FREQ(10),
    .PWM_BITS(4),
    .N_CH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .phase(phase),
    .pwm_out(pwm_out),
    .ramp_wrap(ramp_wrap)
  );

  int tests = 0;
  int fails = 0;

  // Model time: k = clocks since reset release (carrier = k%16, ramp = (k/16)%16).
  int k = 0;
  int md[4];
  int hi[4];
  bit pok[4];
  int cur_r[4];
  int last_hi[4];
  bit last_ok[4];
  int last_r[4];
  int wrap_edges[$];

  function automatic int shape(input int m, input int ph, input int r, input int prev);
    int v;
    v = (r + ph) % 16;
    case (m)
      0: return v;
      1: return 15 - v;
      2: return (v < 8) ? 2 * v : 2 * (15 - v);
      default: return prev;
    endcase
  endfunction

  task automatic tick();
    logic        c_rst;
    logic [3:0]  c_en;
    logic [7:0]  c_mode;
    logic [15:0] c_ph;
    logic [3:0]  exp_pwm;
    bit          exp_wrap;
    int          cb, rb;
    c_rst = rst; c_en = en; c_mode = mode; c_ph = phase;
    @(posedge clk);
    #1;
    exp_pwm = 4'h0;
    exp_wrap = 1'b0;
    if (c_rst) begin
      k = 0;
      for (int ch = 0; ch < 4; ch++) begin
        md[ch] = 0; hi[ch] = 0; pok[ch] = 1'b0; cur_r[ch] = -1;
      end
    end else begin
      cb = k % 16;
      rb = (k / 16) % 16;
      k++;
      exp_wrap = (k % 256 == 0);
      for (int ch = 0; ch < 4; ch++) begin
        exp_pwm[ch] = c_en[ch] && (cb < md[ch]);
        if (cb == 0) begin
          hi[ch] = 0;
          pok[ch] = (cur_r[ch] >= 0);
        end
        if (!c_en[ch]) pok[ch] = 1'b0;
        hi[ch] += int'(pwm_out[ch]);
        if (cb == 15) begin
          if (pok[ch]) begin
            tests++;
            if (hi[ch] !== md[ch]) begin
              fails++;
              $display("FAIL high_count ch%0d k=%0d: got %0d expected %0d", ch, k, hi[ch], md[ch]);
            end
          end
          last_hi[ch] = hi[ch];
          last_ok[ch] = pok[ch];
          last_r[ch]  = cur_r[ch];
          md[ch] = shape(int'(c_mode[2*ch +: 2]), int'(c_ph[4*ch +: 4]), rb, md[ch]);
          cur_r[ch] = rb;
        end
      end
    end
    tests++;
    if (pwm_out !== exp_pwm) begin
      fails++;
      $display("FAIL pwm_out k=%0d: got %b expected %b", k, pwm_out, exp_pwm);
    end
    tests++;
    if (ramp_wrap !== exp_wrap) begin
      fails++;
      $display("FAIL ramp_wrap k=%0d: got %b expected %b", k, ramp_wrap, exp_wrap);
    end
    if (ramp_wrap === 1'b1) wrap_edges.push_back(k);
  endtask

  task automatic align(input int phase_pos);
    for (int i = 0; i < 16 && (k % 16) != phase_pos; i++) tick();
  endtask

  task automatic run_period();
    for (int i = 0; i < 16; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 4'hF;
    mode = {2'b10, 2'b00, 2'b01, 2'b00};
    phase = {4'd0, 4'd8, 4'd0, 4'd0};
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_wrap();
    wrap_edges.delete();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) tick();
    tests++;
    if (wrap_edges.size() != 2) begin
      fails++;
      $display("FAIL wrap_count: got %0d expected 2", wrap_edges.size());
    end else begin
      tests++;
      if (wrap_edges[0] != 256 || wrap_edges[1] != 512) begin
        fails++;
        $display("FAIL wrap_times: got %0d,%0d expected 256,512", wrap_edges[0], wrap_edges[1]);
      end
    end
  endtask

  task automatic test_up_down_phase();
    align(0);
    for (int p = 0; p < 16; p++) begin
      run_period();
      if (last_ok[0] && last_ok[1] && last_ok[2]) begin
        tests++;
        if (last_hi[0] != last_r[0] || last_hi[1] != 15 - last_r[1]) begin
          fails++;
          $display("FAIL up_down r=%0d: got %0d/%0d expected %0d/%0d",
                   last_r[0], last_hi[0], last_hi[1], last_r[0], 15 - last_r[0]);
        end
        tests++;
        if (last_hi[2] != (last_hi[0] + 8) % 16) begin
          fails++;
          $display("FAIL phase8 r=%0d: got %0d expected %0d", last_r[2], last_hi[2], (last_hi[0] + 8) % 16);
        end
      end
    end
  endtask

  task automatic test_tri();
    int e;
    align(0);
    for (int p = 0; p < 16; p++) begin
      run_period();
      if (last_ok[3]) begin
        e = (last_r[3] < 8) ? 2 * last_r[3] : 2 * (15 - last_r[3]);
        tests++;
        if (last_hi[3] != e) begin
          fails++;
          $display("FAIL tri r=%0d: got %0d expected %0d", last_r[3], last_hi[3], e);
        end
        tests++;
        if (last_hi[3] % 2 != 0) begin
          fails++;
          $display("FAIL tri_odd r=%0d: got %0d expected even", last_r[3], last_hi[3]);
        end
      end
    end
  endtask

  task automatic test_hold();
    int h;
    align(5);
    mode[1:0] = 2'b11;
    align(0);
    h = last_hi[0];
    tests++;
    if (h != last_r[0]) begin
      fails++;
      $display("FAIL hold_current: got %0d expected %0d", h, last_r[0]);
    end
    for (int p = 0; p < 3; p++) begin
      run_period();
      tests++;
      if (last_hi[0] != h) begin
        fails++;
        $display("FAIL hold_frozen p=%0d: got %0d expected %0d", p, last_hi[0], h);
      end
    end
    mode[1:0] = 2'b00;
    run_period();
    run_period();
    tests++;
    if (last_hi[0] != last_r[0]) begin
      fails++;
      $display("FAIL hold_release: got %0d expected %0d", last_hi[0], last_r[0]);
    end
  endtask

  task automatic test_enable_reset();
    align(3);
    en[1] = 1'b0;
    tick();
    tests++;
    if (pwm_out[1] !== 1'b0) begin
      fails++;
      $display("FAIL en_off: got %b expected 0", pwm_out[1]);
    end
    align(7);
    rst = 1'b1;
    tick();
    tests++;
    if (pwm_out !== 4'h0 || ramp_wrap !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got %b/%b expected 0000/0", pwm_out, ramp_wrap);
    end
    rst = 1'b0;
    en = 4'hF;
    wrap_edges.delete();
    for (int i = 0; i < 260; i++) tick();
    tests++;
    if (wrap_edges.size() != 1 || (wrap_edges.size() == 1 && wrap_edges[0] != 256)) begin
      fails++;
      $display("FAIL restart_wrap: got %0d wraps first=%0d expected 1 at 256",
               wrap_edges.size(), (wrap_edges.size() > 0) ? wrap_edges[0] : -1);
    end
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 40; s++) begin
      en    = 4'($urandom);
      mode  = 8'($urandom);
      phase = 16'($urandom);
      rst   = ($urandom_range(0, 9) == 0);
      len   = rst ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 60));
      for (int i = 0; i < len; i++) tick();
      rst = 1'b0;
    end
    for (int i = 0; i < 64; i++) tick();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_up_down_phase();
    test_tri();
    test_hold();
    test_enable_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_ramp_pwm.md
MULTI_RAMP_PWM -- requirements
Module: multi_ramp_pwm

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 Parameter RAMP_FREQ, default 1_000, meaning nominal ramp repetition rate in Hz.
REQ-003 Parameter PWM_BITS, default 10, meaning carrier counter, duty and phase width (B); range 3..16.
REQ-004 Parameter N_CH, default 4, meaning number of independent PWM channels; range 1..16.
REQ-005 Port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1, meaning synchronous active-high reset.
REQ-007 Port en, input, N_CH, meaning per-channel output enable.
REQ-008 Port mode, input, 2*N_CH, meaning per-channel mode; field i is mode[2i+1:2i].
REQ-009 Port phase, input, B*N_CH, meaning per-channel ramp phase offset; field i is phase[B*i+B-1:B*i].
REQ-010 Port pwm_out, output, N_CH, meaning registered PWM outputs.
REQ-011 Port ramp_wrap, output, 1, meaning single-cycle pulse when the shared ramp wraps to 0.

Function
REQ-012 STEP_DIV = CLK_HZ / (RAMP_FREQ * 2^B), integer division; STEP_DIV < 1 shall be an elaboration error.
REQ-013 Carrier counter cnt (B bits) shall increment every clock and wrap MAX=2^B-1 -> 0; the carrier period is 2^B clocks.
REQ-014 Step divider shall count 0..STEP_DIV-1 and assert step_tick on the terminal count; shared ramp r (B bits) shall increment on step_tick and wrap MAX -> 0.
REQ-015 ramp_wrap shall be 1 for exactly the clock after r transitions MAX -> 0; the ramp period is STEP_DIV*2^B clocks.
REQ-016 Per channel, v_i = (r + phase_i) mod 2^B.
REQ-017 Mode 00 (UP): shaped = v_i; mode 01 (DOWN): shaped = MAX - v_i.
REQ-018 Mode 10 (TRI): shaped = v_i[B-1]==0 ? {v_i[B-2:0],0} : {~v_i[B-2:0],0}, giving 0,2,..,MAX-1,MAX-1,..,2,0.
REQ-019 Mode 11 (HOLD): duty_i shall keep its current value.
REQ-020 duty_i shall load shaped on the edge where cnt==MAX only (carrier boundary); en, mode and phase changes elsewhere shall not alter the running period.
REQ-021 pwm_out[i] shall be registered: pwm_out[i] <= en[i] & (cnt < duty_i); latency is one clock from cnt.
REQ-022 High time per carrier period shall equal duty_i clocks; duty 0 gives a constant 0, duty MAX gives 1 for MAX of 2^B clocks.
REQ-023 en[i] deasserted shall force pwm_out[i] to 0 on the next edge; duty_i shall keep updating while disabled.
REQ-024 r wrap and cnt wrap on the same edge shall latch duty from the pre-wrap r value (MAX + phase).

Reset
REQ-025 While rst=1 at an edge: cnt=0, step divider=0, r=0, all duty_i=0, pwm_out=0, ramp_wrap=0.
REQ-026 rst asserted mid-period shall abort the period; after release, counting shall restart from cnt=0, r=0 with no residual pulse.

Structure
REQ-027 Package multi_ramp_pwm_pkg shall hold mode encodings MODE_UP, MODE_DOWN, MODE_TRI, MODE_HOLD and the STEP_DIV calculation function.
REQ-028 Sub-module pwm_channel (shaper, duty register, output compare/register) shall be instantiated N_CH times; cnt, divider and r stay in the top level.

Verification (CLK_HZ=2560, RAMP_FREQ=10, B=4 -> STEP_DIV=16, ramp period 256 clocks, N_CH=4)
REQ-029 rst=1 for 10 clocks, en=4'hF -> pwm_out=0 and ramp_wrap=0 throughout reset; first ramp_wrap 256 clocks after release, then every 256 clocks, width 1.
REQ-030 ch0 UP phase 0, ch1 DOWN phase 0 -> in every carrier period, high count of ch0 = d and high count of ch1 = 15-d, with d = r sampled at cnt==15.
REQ-031 ch2 UP phase 8 -> duty2 = (duty0 + 8) mod 16 in every period; compare against a reference model.
REQ-032 ch3 TRI phase 0 -> per-period duty sequence over one ramp is 0,2,4,..,14,14,12,..,0; no odd value appears.
REQ-033 Switch ch0 from UP to HOLD at cnt=5 -> current period unaffected; duty0 frozen at the last latched value until mode changes back.
REQ-034 en[1]=0 at cnt=3 -> pwm_out[1]=0 on the next edge; rst=1 at cnt=7 -> all outputs 0 on the next edge, restart from cnt=0, r=0.
